// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the data-memory initiator and its bus interface.
package mem_if_pkg;

  // Transaction sequencing states of the memory initiator.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT_RDY,
    S_RESP
  } state_e;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int MEM_SETTLE_MIN = 2;

  // Width for a counter that must reach the larger of the settle and
  // timeout limits without wrapping.
  function automatic int cntWidth(input int settle, input int timeout);
    int maxVal;
    maxVal = (settle > timeout) ? settle : timeout;
    return $clog2(maxVal) + 1;
  endfunction

endpackage

// File: rtl/mem_master_if.sv
// Core-side request/response handshake plus the single-port memory pins.
interface mem_master_if
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic              memory_w;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] i0;
  logic [DATA_W-1:0] o0;
  logic              memory_ready;

  // View of the initiator sitting between the core and the memory.
  modport master (
    input  req_valid, req_write, req_addr, req_data, rsp_ready, o0, memory_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, memory_w, addr, i0
  );

  // View of whatever drives the core requests and models the memory.
  modport slave (
    output req_valid, req_write, req_addr, req_data, rsp_ready, o0, memory_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, memory_w, addr, i0
  );

endinterface

// File: rtl/mem_master.sv
// Single-outstanding load/store initiator for the data memory: issues a
// one-cycle write strobe, waits a fixed settle time, then waits (bounded)
// for memory_ready and returns read data, a store echo, or a timeout error.
// SETTLE must be at least MEM_SETTLE_MIN and TIMEOUT at least 1.
module mem_master
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  mem_master_if.master bus
);

  localparam int             CNT_W       = cntWidth(SETTLE, TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                write_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic                memory_w_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   i0_q;

  // Whole transaction sequencer; every bus output comes straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      memory_w_q  <= 1'b0;
      addr_q      <= '0;
      i0_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            addr_q      <= bus.req_addr;
            i0_q        <= bus.req_data;
            memory_w_q  <= bus.req_write;
            write_q     <= bus.req_write;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          memory_w_q <= 1'b0;
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_WAIT_RDY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_RDY: begin
          if (bus.memory_ready) begin
            rsp_data_q  <= write_q ? i0_q : bus.o0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (cnt_q == TIMEOUT_CNT) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.memory_w  = memory_w_q;
  assign bus.addr      = addr_q;
  assign bus.i0        = i0_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a small behavioural memory responder.
module tb_mem_master;

  logic clk;
  logic rst;
  logic stubNotReady;

  mem_master_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_master #(
    .ADDR_W (16),
    .DATA_W (16),
    .SETTLE (2),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural memory: writes on memory_w, combinational read, and
  // memory_ready drops for one cycle after a write or an address change.
  logic [15:0] mem [0:255];
  logic [15:0] lastAddr;
  logic        memRdy;

  always @(posedge clk) begin
    if (bus.memory_w) mem[bus.addr[7:0]] <= bus.i0;
    memRdy   <= !(bus.memory_w || (bus.addr != lastAddr));
    lastAddr <= bus.addr;
  end

  assign bus.memory_ready = memRdy && !stubNotReady;
  assign bus.o0           = mem[bus.addr[7:0]];

  int checks;
  int errors;
  int latency;
  int memWCount;
  logic readyLowOk;

  // Single comparison point; every failure prints one FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for the response, recording the
  // latency from the accepting edge, strobe cycles and req_ready behaviour.
  task automatic applyStimulus(input logic wr, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    checkOutput("req_ready before accept", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_data  = d;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    latency    = 0;
    memWCount  = 0;
    readyLowOk = 1'b1;
    while (!bus.rsp_valid && latency < 40) begin
      if (bus.memory_w) memWCount++;
      if (bus.req_ready) readyLowOk = 1'b0;
      @(posedge clk);
      @(negedge clk);
      latency++;
    end
    if (bus.req_ready) readyLowOk = 1'b0;
  endtask

  // Complete the response handshake and confirm the block is idle again.
  task automatic finishResponse();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkOutput("rsp_valid after handshake", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("req_ready after handshake", {31'd0, bus.req_ready}, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] expData;
  } vec_t;

  vec_t vecs [8];
  logic [15:0] heldData;

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    lastAddr      = 16'h0;
    memRdy        = 1'b1;
    stubNotReady  = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;

    vecs[0] = '{wr: 1'b1, addr: 16'h0010, data: 16'h1234, expData: 16'h1234};
    vecs[1] = '{wr: 1'b0, addr: 16'h0010, data: 16'h0000, expData: 16'h1234};
    vecs[2] = '{wr: 1'b0, addr: 16'h0010, data: 16'h0000, expData: 16'h1234};
    vecs[3] = '{wr: 1'b0, addr: 16'h0000, data: 16'h0000, expData: 16'h0000};
    vecs[4] = '{wr: 1'b0, addr: 16'h0001, data: 16'h0000, expData: 16'h0001};
    vecs[5] = '{wr: 1'b1, addr: 16'h0001, data: 16'hBEEF, expData: 16'hBEEF};
    vecs[6] = '{wr: 1'b0, addr: 16'h0001, data: 16'h5555, expData: 16'hBEEF};
    vecs[7] = '{wr: 1'b1, addr: 16'h00FF, data: 16'hA5A5, expData: 16'hA5A5};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    checkOutput("reset rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    checkOutput("reset memory_w", {31'd0, bus.memory_w}, 32'd0);
    checkOutput("reset addr", {16'd0, bus.addr}, 32'd0);
    checkOutput("reset i0", {16'd0, bus.i0}, 32'd0);

    // Table of ordinary loads and stores: 3-cycle latency, no error.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("vec%0d latency", i), 32'(latency), 32'd3);
      checkOutput($sformatf("vec%0d rsp_data", i), {16'd0, bus.rsp_data}, {16'd0, vecs[i].expData});
      checkOutput($sformatf("vec%0d rsp_err", i), {31'd0, bus.rsp_err}, 32'd0);
      checkOutput($sformatf("vec%0d strobe cycles", i), 32'(memWCount), {31'd0, vecs[i].wr});
      checkOutput($sformatf("vec%0d req_ready low", i), {31'd0, readyLowOk}, 32'd1);
      checkOutput($sformatf("vec%0d addr port", i), {16'd0, bus.addr}, {16'd0, vecs[i].addr});
      if (vecs[i].wr)
        checkOutput($sformatf("vec%0d i0 port", i), {16'd0, bus.i0}, {16'd0, vecs[i].data});
      finishResponse();
    end

    // Response stall: data held and new requests ignored while rsp_ready=0.
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    checkOutput("stall first rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    heldData      = bus.rsp_data;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h0055;
    bus.req_data  = 16'hDEAD;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput("stall rsp_data", {16'd0, bus.rsp_data}, {16'd0, heldData});
      checkOutput("stall req_ready", {31'd0, bus.req_ready}, 32'd0);
      checkOutput("stall memory_w", {31'd0, bus.memory_w}, 32'd0);
      checkOutput("stall addr", {16'd0, bus.addr}, 32'h0000);
    end
    bus.req_valid = 1'b0;
    finishResponse();
    checkOutput("stalled store not written", {16'd0, mem[8'h55]}, 32'h0055);

    // Memory never ready: timeout error after SETTLE+TIMEOUT+1 cycles.
    stubNotReady = 1'b1;
    applyStimulus(1'b0, 16'h0003, 16'h0000);
    checkOutput("timeout latency", 32'(latency), 32'd19);
    checkOutput("timeout rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    checkOutput("timeout rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    finishResponse();
    checkOutput("timeout rsp_err cleared", {31'd0, bus.rsp_err}, 32'd0);
    stubNotReady = 1'b0;
    applyStimulus(1'b0, 16'h0004, 16'h0000);
    checkOutput("post-timeout latency", 32'(latency), 32'd3);
    checkOutput("post-timeout rsp_data", {16'd0, bus.rsp_data}, 32'h0004);
    checkOutput("post-timeout rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    finishResponse();

    // Reset while a store is settling abandons it without a response.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h0020;
    bus.req_data  = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("pre-reset memory_w", {31'd0, bus.memory_w}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("mid-reset memory_w", {31'd0, bus.memory_w}, 32'd0);
    checkOutput("mid-reset addr", {16'd0, bus.addr}, 32'd0);
    memWCount = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus.rsp_valid) memWCount++;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("abandoned rsp_valid cycles", 32'(memWCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
